// File: rtl/date_counter.sv
// date_counter: calendar date register (day / month / year offset from 2000).
//   Advances one day on each day_tick and loads a user date on set_en after
//   validating it. A set takes one extra cycle (LOAD state), and ticks that
//   arrive with set_en or during LOAD are discarded.
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset to RST_DAY/RST_MON/RST_YEAR
//   day_tick   one-cycle midnight pulse
//   set_en     one-cycle load strobe; set_day/set_mon/set_year hold the date
//   Day_Date   day of month (1..31), registered
//   Mon_Date   month (1..12), registered
//   Year_Date  year offset from 2000 (0..99), registered
//   set_err    one-cycle pulse when a set is rejected
//   year_wrap  one-cycle pulse when the year rolls 99 -> 0
// Build option: define DATE_COUNTER_LEAP_EN to give February 29 days when
//   the year offset is a multiple of 4; otherwise February always has 28.
module date_counter #(
  parameter int RST_DAY  = 1,
  parameter int RST_MON  = 1,
  parameter int RST_YEAR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       set_en,
  input  logic [5:0] set_day,
  input  logic [3:0] set_mon,
  input  logic [6:0] set_year,
  output logic [5:0] Day_Date,
  output logic [3:0] Mon_Date,
  output logic [6:0] Year_Date,
  output logic       set_err,
  output logic       year_wrap
);

  localparam logic [5:0] RST_D = RST_DAY[5:0];
  localparam logic [3:0] RST_M = RST_MON[3:0];
  localparam logic [6:0] RST_Y = RST_YEAR[6:0];

  typedef enum logic {RUN, LOAD} state_t;

  state_t     r_state, w_next_state;
  logic [5:0] r_day, w_day;
  logic [3:0] r_mon, w_mon;
  logic [6:0] r_year, w_year;
  logic       r_set_err, w_set_err;
  logic       r_year_wrap, w_year_wrap;

  // Set fields captured when set_en is taken; validated and committed in LOAD.
  logic [5:0] r_ld_day;
  logic [3:0] r_ld_mon;
  logic [6:0] r_ld_year;

  logic       w_cur_leap, w_ld_leap;
  logic [5:0] w_cur_dim, w_ld_dim;
  logic       w_ld_valid;

  function automatic logic [5:0] days_in_month(input logic [3:0] m, input logic leap);
    logic [5:0] d;
    case (m)
      4'd2:                      d = leap ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   d = 6'd30;
      default:                   d = 6'd31;
    endcase
    return d;
  endfunction

`ifdef DATE_COUNTER_LEAP_EN
  assign w_cur_leap = (r_year[1:0] == 2'b00);
  assign w_ld_leap  = (r_ld_year[1:0] == 2'b00);
`else
  assign w_cur_leap = 1'b0;
  assign w_ld_leap  = 1'b0;
`endif

  assign w_cur_dim  = days_in_month(r_mon, w_cur_leap);
  assign w_ld_dim   = days_in_month(r_ld_mon, w_ld_leap);
  assign w_ld_valid = (r_ld_mon >= 4'd1) && (r_ld_mon <= 4'd12) &&
                      (r_ld_year <= 7'd99) &&
                      (r_ld_day >= 6'd1) && (r_ld_day <= w_ld_dim);

  always_comb begin
    w_next_state = r_state;
    w_day        = r_day;
    w_mon        = r_mon;
    w_year       = r_year;
    w_set_err    = 1'b0;
    w_year_wrap  = 1'b0;
    case (r_state)
      RUN: begin
        if (set_en) begin
          // set_en wins over a coincident tick; the tick is dropped.
          w_next_state = LOAD;
        end else if (day_tick) begin
          if (r_day < w_cur_dim) begin
            w_day = r_day + 6'd1;
          end else begin
            w_day = 6'd1;
            if (r_mon == 4'd12) begin
              w_mon = 4'd1;
              if (r_year >= 7'd99) begin
                w_year      = '0;
                w_year_wrap = 1'b1;
              end else begin
                w_year = r_year + 7'd1;
              end
            end else begin
              w_mon = r_mon + 4'd1;
            end
          end
        end
      end
      LOAD: begin
        w_next_state = RUN;
        if (w_ld_valid) begin
          w_day  = r_ld_day;
          w_mon  = r_ld_mon;
          w_year = r_ld_year;
        end else begin
          w_set_err = 1'b1;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_day       <= RST_D;
      r_mon       <= RST_M;
      r_year      <= RST_Y;
      r_set_err   <= 1'b0;
      r_year_wrap <= 1'b0;
      r_ld_day    <= '0;
      r_ld_mon    <= '0;
      r_ld_year   <= '0;
    end else begin
      r_state     <= w_next_state;
      r_day       <= w_day;
      r_mon       <= w_mon;
      r_year      <= w_year;
      r_set_err   <= w_set_err;
      r_year_wrap <= w_year_wrap;
      if (r_state == RUN && set_en) begin
        r_ld_day  <= set_day;
        r_ld_mon  <= set_mon;
        r_ld_year <= set_year;
      end
    end
  end

  assign Day_Date  = r_day;
  assign Mon_Date  = r_mon;
  assign Year_Date = r_year;
  assign set_err   = r_set_err;
  assign year_wrap = r_year_wrap;

endmodule

// File: tb/tb_date_counter.sv
module tb_date_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       day_tick = 1'b0;
  logic       set_en = 1'b0;
  logic [5:0] set_day = '0;
  logic [3:0] set_mon = '0;
  logic [6:0] set_year = '0;
  logic [5:0] Day_Date;
  logic [3:0] Mon_Date;
  logic [6:0] Year_Date;
  logic       set_err;
  logic       year_wrap;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  date_counter #(.RST_DAY(1), .RST_MON(1), .RST_YEAR(0)) dut (
    .clk(clk), .rst(rst), .day_tick(day_tick), .set_en(set_en),
    .set_day(set_day), .set_mon(set_mon), .set_year(set_year),
    .Day_Date(Day_Date), .Mon_Date(Mon_Date), .Year_Date(Year_Date),
    .set_err(set_err), .year_wrap(year_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_date(input string tag, input int d, input int m, input int y);
    chk({tag, ".day"}, int'(Day_Date), d);
    chk({tag, ".mon"}, int'(Mon_Date), m);
    chk({tag, ".year"}, int'(Year_Date), y);
  endtask

  // Pulse set_en for one cycle, then wait for the LOAD commit edge.
  // Returns sampled just after the commit edge (set_err visible).
  task automatic do_set(input int d, input int m, input int y);
    @(negedge clk);
    set_en = 1'b1; set_day = d[5:0]; set_mon = m[3:0]; set_year = y[6:0];
    @(negedge clk);
    set_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    day_tick = 1'b1;
    @(negedge clk);
    day_tick = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_date("rst", 1, 1, 0);
    chk("rst.set_err", int'(set_err), 0);
    chk("rst.year_wrap", int'(year_wrap), 0);
    rst = 1'b0;

    // Plain increments and month ends
    tick();
    chk_date("inc", 2, 1, 0);
    do_set(30, 4, 10);
    chk("set304.err", int'(set_err), 0);
    chk_date("set304", 30, 4, 10);
    tick();
    chk_date("apr_end", 1, 5, 10);
    do_set(31, 1, 10);
    tick();
    chk_date("jan_end", 1, 2, 10);

    // February
    do_set(28, 2, 24);
    chk_date("set282", 28, 2, 24);
    tick();
`ifdef DATE_COUNTER_LEAP_EN
    chk_date("leap29", 29, 2, 24);
    tick();
    chk_date("leap_end", 1, 3, 24);
    do_set(29, 2, 24);
    chk("set2924.err", int'(set_err), 0);
    chk_date("set2924", 29, 2, 24);
`else
    chk_date("feb_end", 1, 3, 24);
    do_set(29, 2, 24);
    chk("set2924.err", int'(set_err), 1);
    chk_date("set2924.hold", 1, 3, 24);
`endif
    do_set(28, 2, 23);
    tick();
    chk_date("feb23_end", 1, 3, 23);

    // Year wrap
    do_set(31, 12, 99);
    chk_date("set3112", 31, 12, 99);
    tick();
    chk_date("wrap", 1, 1, 0);
    chk("wrap.pulse", int'(year_wrap), 1);
    @(negedge clk);
    chk("wrap.pulse_end", int'(year_wrap), 0);
    do_set(31, 12, 50);
    tick();
    chk_date("newyear", 1, 1, 51);
    chk("newyear.nowrap", int'(year_wrap), 0);

    // Invalid sets leave the date alone
    do_set(31, 4, 10);
    chk("bad314.err", int'(set_err), 1);
    chk_date("bad314", 1, 1, 51);
    @(negedge clk);
    chk("bad314.err_end", int'(set_err), 0);
    do_set(29, 2, 23);
    chk("bad2923.err", int'(set_err), 1);
    do_set(15, 13, 10);
    chk("badmon.err", int'(set_err), 1);
    do_set(0, 5, 10);
    chk("badday.err", int'(set_err), 1);
    do_set(10, 5, 100);
    chk("badyear.err", int'(set_err), 1);
    chk_date("bad.hold", 1, 1, 51);

    // Collision: set with tick, tick held through LOAD too
    do_set(30, 6, 5);
    @(negedge clk);
    set_en = 1'b1; day_tick = 1'b1; set_day = 6'd15; set_mon = 4'd8; set_year = 7'd7;
    @(negedge clk);
    set_en = 1'b0;
    @(negedge clk);
    day_tick = 1'b0;
    chk_date("collide", 15, 8, 7);
    chk("collide.err", int'(set_err), 0);

    // Invalid set colliding with tick: tick still discarded
    @(negedge clk);
    set_en = 1'b1; day_tick = 1'b1; set_day = 6'd31; set_mon = 4'd9; set_year = 7'd7;
    @(negedge clk);
    set_en = 1'b0; day_tick = 1'b0;
    @(negedge clk);
    chk("collide_bad.err", int'(set_err), 1);
    chk_date("collide_bad", 15, 8, 7);

    // Asynchronous reset mid-LOAD abandons the set
    @(negedge clk);
    set_en = 1'b1; set_day = 6'd20; set_mon = 4'd10; set_year = 7'd30;
    @(negedge clk);
    set_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_date("arst", 1, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_date("arst.after", 1, 1, 0);
    chk("arst.err", int'(set_err), 0);
    tick();
    chk_date("arst.tick", 2, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
